flagged_string_loader: RTL and testbench

- Writer side of the string comparator's pattern interface.
- Accepts a byte-serial configuration stream from the host/control path and assembles the flagged string in a shadow register.
- Atomically commits the assembled string to flagged_string and strlen, then pulses clear so the comparator restarts matching on the new pattern.
- Sits between the host configuration logic and string_comparator in the sniffer datapath.

---
 rtl/string_cfg_pkg.sv | 16 +
 rtl/flagged_string_loader_if.sv | 26 ++
 rtl/pattern_shift_reg.sv | 30 +++
 rtl/flagged_string_loader.sv | 142 ++++++++++++++
 tb/tb_flagged_string_loader.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/string_cfg_pkg.sv
// rtl/string_cfg_pkg.sv - shared pattern constants, pattern type and loader state encoding
package string_cfg_pkg;

    localparam int MAX_LEN = 17;
    localparam int LEN_W   = 5;

    typedef logic [0:MAX_LEN-1][7:0] pattern_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        COMMIT
    } state_t;

endpackage

// File: rtl/flagged_string_loader_if.sv
// rtl/flagged_string_loader_if.sv - byte-serial pattern configuration channel
interface flagged_string_loader_if;

    logic       cfg_valid;
    logic [7:0] cfg_byte;
    logic       cfg_last;
    logic       cfg_flush;
    logic       cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_byte,
        output cfg_last,
        output cfg_flush,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_byte,
        input  cfg_last,
        input  cfg_flush,
        output cfg_ready
    );

endinterface

// File: rtl/pattern_shift_reg.sv
// rtl/pattern_shift_reg.sv - byte shift register filling from the right end toward index 0
module pattern_shift_reg #(
    parameter int MAX_LEN = 17
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     clr,
    input  logic                     shift,
    input  logic [7:0]               din,
    output logic [0:MAX_LEN-1][7:0]  q
);

    logic [0:MAX_LEN-1][7:0] base;

    // clr together with shift starts a fresh pattern with din as its only byte
    always_comb begin
        base = clr ? '0 : q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q <= '0;
        end else if (shift) begin
            q <= {base[1:MAX_LEN-1], din};
        end else if (clr) begin
            q <= '0;
        end
    end

endmodule

// File: rtl/flagged_string_loader.sv
// rtl/flagged_string_loader.sv - assembles a flagged string from a byte stream and commits it atomically
module flagged_string_loader #(
    parameter int MAX_LEN = string_cfg_pkg::MAX_LEN,
    parameter int LEN_W   = string_cfg_pkg::LEN_W
) (
    input  logic                     clk,
    input  logic                     n_rst,
    flagged_string_loader_if.slave   cfg,
    output logic [0:MAX_LEN-1][7:0]  flagged_string,
    output logic [LEN_W-1:0]         strlen,
    output logic                     string_valid,
    output logic                     clear,
    output logic                     load_error
);

    import string_cfg_pkg::*;

    localparam logic [LEN_W-1:0] CNT_FULL = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] CNT_SAT  = LEN_W'(MAX_LEN + 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [LEN_W-1:0]        count;
    logic [LEN_W-1:0]        count_nxt;
    logic                    accept;
    logic                    sh_clear;
    logic                    sh_shift;
    logic                    do_commit;
    logic                    do_error;
    logic [0:MAX_LEN-1][7:0] shadow;

    // Flush blocks the byte in the same cycle so it can never leak into a fresh pattern
    assign cfg.cfg_ready = (state != COMMIT) && !cfg.cfg_flush;
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;

    pattern_shift_reg #(
        .MAX_LEN (MAX_LEN)
    ) u_shadow (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (sh_clear),
        .shift (sh_shift),
        .din   (cfg.cfg_byte),
        .q     (shadow)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        sh_clear  = 1'b0;
        sh_shift  = 1'b0;
        do_commit = 1'b0;
        do_error  = 1'b0;
        if (cfg.cfg_flush) begin
            state_nxt = IDLE;
            count_nxt = '0;
            sh_clear  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh_clear  = 1'b1;
                        sh_shift  = 1'b1;
                        count_nxt = LEN_W'(1);
                        state_nxt = cfg.cfg_last ? COMMIT : LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (count < CNT_FULL) begin
                            sh_shift  = 1'b1;
                            count_nxt = count + LEN_W'(1);
                            if (cfg.cfg_last) begin
                                state_nxt = COMMIT;
                            end
                        end else begin
                            // Overflow: keep swallowing until the host ends the pattern
                            count_nxt = CNT_SAT;
                            if (cfg.cfg_last) begin
                                do_error  = 1'b1;
                                state_nxt = IDLE;
                            end else begin
                                state_nxt = DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        count_nxt = CNT_SAT;
                        if (cfg.cfg_last) begin
                            do_error  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                COMMIT: begin
                    do_commit = 1'b1;
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            flagged_string <= '0;
            strlen         <= '0;
            string_valid   <= 1'b0;
            clear          <= 1'b0;
            load_error     <= 1'b0;
        end else begin
            clear      <= 1'b0;
            load_error <= do_error;
            if (cfg.cfg_flush) begin
                flagged_string <= '0;
                strlen         <= '0;
                string_valid   <= 1'b0;
                clear          <= 1'b1;
            end else if (do_commit) begin
                flagged_string <= shadow;
                strlen         <= count;
                string_valid   <= 1'b1;
                clear          <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flagged_string_loader.sv
// tb/tb_flagged_string_loader.sv - scoreboard bench for flagged_string_loader
module tb_flagged_string_loader;

    import string_cfg_pkg::*;

    localparam int CW = 8 * MAX_LEN;
    typedef logic [CW-1:0] cv_t;

    localparam int EV_COMMIT = 0;
    localparam int EV_FLUSH  = 1;
    localparam int EV_ERROR  = 2;

    typedef struct {
        int       kind;
        pattern_t pat;
        int       len;
    } ev_t;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    pattern_t         flagged_string;
    logic [LEN_W-1:0] strlen;
    logic             string_valid;
    logic             clear;
    logic             load_error;

    flagged_string_loader_if cfg();

    flagged_string_loader dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .cfg            (cfg),
        .flagged_string (flagged_string),
        .strlen         (strlen),
        .string_valid   (string_valid),
        .clear          (clear),
        .load_error     (load_error)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    ev_t         exp_q[$];
    logic [7:0]  cur[$];
    bit          commit_pending = 0;
    pattern_t    pend_pat;
    int          pend_len;

    function automatic void chk(input string name, input cv_t act, input cv_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference rule: the first byte is the leftmost char, the last lands at index MAX_LEN-1
    function automatic pattern_t justify(input logic [7:0] q[$]);
        pattern_t p = '0;
        for (int i = 0; i < q.size(); i++) begin
            p[MAX_LEN - q.size() + i] = q[i];
        end
        return p;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    pattern_t m_pat   = '0;
    int       m_len   = 0;
    bit       m_valid = 0;

    always @(negedge clk) begin
        ev_t e;
        if (!n_rst) begin
            m_pat   = '0;
            m_len   = 0;
            m_valid = 0;
        end else begin
            if (clear || load_error) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", cv_t'({clear, load_error}), cv_t'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_clear", cv_t'(clear), cv_t'(e.kind != EV_ERROR));
                    chk("ev_load_error", cv_t'(load_error), cv_t'(e.kind == EV_ERROR));
                    if (e.kind == EV_COMMIT) begin
                        m_pat = e.pat; m_len = e.len; m_valid = 1;
                    end else if (e.kind == EV_FLUSH) begin
                        m_pat = '0; m_len = 0; m_valid = 0;
                    end
                end
            end
            chk("flagged_string", cv_t'(flagged_string), cv_t'(m_pat));
            chk("strlen", cv_t'(strlen), cv_t'(m_len));
            chk("string_valid", cv_t'(string_valid), cv_t'(m_valid));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_cycle(input bit v, input logic [7:0] b, input bit last,
                               input bit flush, output bit acc);
        ev_t e;
        bit  exp_ready;
        if (flush) begin
            commit_pending = 0;
            cur.delete();
            e.kind = EV_FLUSH; e.pat = '0; e.len = 0;
            exp_q.push_back(e);
        end else if (commit_pending) begin
            e.kind = EV_COMMIT; e.pat = pend_pat; e.len = pend_len;
            exp_q.push_back(e);
        end
        exp_ready = !flush && !commit_pending;
        cfg.cfg_valid = v;
        cfg.cfg_byte  = b;
        cfg.cfg_last  = last;
        cfg.cfg_flush = flush;
        @(negedge clk);
        chk("cfg_ready", cv_t'(cfg.cfg_ready), cv_t'(exp_ready));
        acc = v && exp_ready;
        @(posedge clk);
        #1;
        commit_pending = 0;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_last  = 1'b0;
        cfg.cfg_flush = 1'b0;
        if (acc) begin
            cur.push_back(b);
            if (last) begin
                if (cur.size() <= MAX_LEN) begin
                    pend_pat = justify(cur);
                    pend_len = cur.size();
                    commit_pending = 1;
                end else begin
                    e.kind = EV_ERROR; e.pat = '0; e.len = 0;
                    exp_q.push_back(e);
                end
                cur.delete();
            end
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive_cycle(0, 8'h00, 0, 0, acc);
    endtask

    // abort_at >= 0 flushes in place of that byte; flush_commit flushes the cycle after the last byte
    task automatic send_q(input logic [7:0] q[$], input int gap_max, input bit do_last,
                          input bit flush_commit, input int abort_at);
        bit acc;
        int tries;
        for (int i = 0; i < q.size(); i++) begin
            if (gap_max > 0) idle($urandom_range(gap_max, 0));
            if (i == abort_at) begin
                drive_cycle(bit'($urandom_range(1, 0)), q[i], 0, 1, acc);
                return;
            end
            tries = 0;
            do begin
                drive_cycle(1, q[i], do_last && (i == q.size() - 1), 0, acc);
                tries++;
            end while (!acc && tries < 4);
            chk("byte_accepted", cv_t'(acc), cv_t'(1));
        end
        if (flush_commit) drive_cycle(0, 8'h00, 0, 1, acc);
    endtask

    task automatic send_str(input string s, input bit do_last, input bit flush_commit);
        logic [7:0] q[$];
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        send_q(q, 0, do_last, flush_commit, -1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_flagged_string", cv_t'(flagged_string), cv_t'(0));
        chk("rst_strlen", cv_t'(strlen), cv_t'(0));
        chk("rst_string_valid", cv_t'(string_valid), cv_t'(0));
        chk("rst_clear", cv_t'(clear), cv_t'(0));
        chk("rst_load_error", cv_t'(load_error), cv_t'(0));
        chk("rst_cfg_ready", cv_t'(cfg.cfg_ready), cv_t'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        logic [7:0] q[$];
        int len;
        int abort_at;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_byte  = 8'h00;
        cfg.cfg_last  = 1'b0;
        cfg.cfg_flush = 1'b0;
        #3;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;

        send_str("www.google.com", 1, 0);
        idle(3);

        // Async reset in the middle of a load discards the partial pattern
        send_str("xyz", 0, 0);
        n_rst = 1'b0;
        #2;
        check_reset_outputs();
        cur.delete();
        commit_pending = 0;
        @(posedge clk);
        #1 n_rst = 1'b1;

        send_str("abc", 1, 0);
        idle(2);
        send_str("www.linkedin.com/", 1, 0);
        idle(2);
        send_str("www.linkedin.com/x", 1, 0);
        idle(2);
        send_str("www.linkedin.com/xyz", 1, 0);
        idle(2);
        send_str("abc", 1, 0);
        send_str("xy", 1, 0);
        idle(2);
        drive_cycle(1, 8'h55, 0, 1, acc);
        idle(2);
        send_str("abc", 1, 1);
        idle(2);
        send_str("a", 1, 0);
        idle(2);

        for (int n = 0; n < 60; n++) begin
            q.delete();
            len = $urandom_range(21, 1);
            for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(255, 1)));
            abort_at = ($urandom_range(9, 0) == 0) ? int'($urandom_range(len - 1, 0)) : -1;
            send_q(q, $urandom_range(2, 0), 1, $urandom_range(7, 0) == 0, abort_at);
            if ($urandom_range(3, 0) == 0) idle($urandom_range(3, 1));
        end

        idle(3);
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) idle(1);
        chk("queue_empty", cv_t'(exp_q.size()), cv_t'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
